seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of scanned digits (1..8).
REQ-002 SHALL have parameter STABLE, default 3: consecutive identical samples required before commit (2..15).
REQ-003 SHALL have port clk  input  1: sole clock, rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port an  input  NDIG: active-low digit select, bit i selects digit i.
REQ-006 SHALL have port seg  input  7: active-low segments, bit0=a .. bit6=g.
REQ-007 SHALL have port value  output  4*NDIG: decoded nibbles, digit i at bits [4i+3:4i].
REQ-008 SHALL have port digit_ok  output  NDIG: bit i high if digit i's last commit was a legal hex pattern.
REQ-009 SHALL have port upd  output  1: one-cycle pulse on each commit.
REQ-010 SHALL have port upd_idx  output  3: digit index of the current commit, valid while upd is high.
REQ-011 SHALL have port err  output  1: one-cycle pulse when a commit holds an illegal pattern.
REQ-012 SHALL have port frame  output  1: one-cycle pulse when every digit has committed since the last frame pulse or reset.

Function
REQ-013 SHALL register an and seg every cycle (input stage).
REQ-014 SHALL treat a sample as valid only when exactly one bit of an is low; otherwise run count = 0.
REQ-015 SHALL increment a run counter, saturating at STABLE, while the valid {an,seg} pair equals the previous sample; on a change it SHALL restart the count at 1.
REQ-016 SHALL commit exactly once per run, on the cycle the count reaches STABLE; outputs for a pair sampled on edges k..k+STABLE-1 SHALL be visible after edge k+STABLE.
REQ-017 SHALL decode with these active-low patterns (hex, g..a): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 On a legal pattern, the block SHALL write the nibble to value slot i and set digit_ok[i].
REQ-019 On blank (7F), the block SHALL clear digit_ok[i], leave value slot i unchanged, and not pulse err.
REQ-020 On any other pattern, the block SHALL clear digit_ok[i], leave value slot i unchanged, and pulse err with upd.
REQ-021 SHALL track a per-digit seen mask; when a commit completes the mask, it SHALL pulse frame in the same cycle as upd and clear the mask.
REQ-022 A commit to an already-seen digit before the frame completes SHALL update value without affecting the mask.

Reset
REQ-023 On rst, the block SHALL clear value, digit_ok, upd, upd_idx, err, frame, the run counter, the seen mask and the input registers.
REQ-024 A run in progress at rst SHALL be discarded; counting SHALL restart from the first sample after rst deasserts.

Configuration
REQ-025 With SEG_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits), incremented on each err pulse, saturating at 255, and cleared by rst.
REQ-026 Without SEG_ERR_CNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 The shared package seg_defs SHALL hold the 16 pattern constants, the blank constant 7F, and the STABLE default.
REQ-028 Pattern decoding SHALL live in a combinational sub-module seg_pattern_decode: seg in; nibble, legal and blank out.

Verification
REQ-029 Scenario (NDIG=4, STABLE=3): hold an=1110, seg=30 for 3 edges -> upd=1, upd_idx=0, value[3:0]=3, digit_ok[0]=1, one cycle only; holding longer gives no further upd.
REQ-030 Scenario: scan digits 0..3 with patterns 40,79,24,30, each held 4 cycles -> four upd pulses, value=16'h3210, frame high with the 4th upd, digit_ok=1111.
REQ-031 Scenario: digit 2 held at seg=7F -> upd with err=0, digit_ok[2]=0, value[11:8] unchanged; then seg=55 -> err pulse, digit_ok[2]=0 (err_cnt=1 when SEG_ERR_CNT_EN is defined).
REQ-032 Scenario: seg toggles every 2 cycles, or an=1100 / an=1111 for 10 cycles -> no upd, no err.
REQ-033 Scenario: rst asserted after 2 of 3 stable samples -> all outputs 0; after release, 3 fresh samples are needed before upd.
REQ-034 Scenario: 300 illegal commits with SEG_ERR_CNT_EN defined -> err_cnt saturates at 255.

Source files
------------

// File: rtl/seg_defs.sv
// Shared seven-segment constants: active-low hex glyphs (g..a), blank glyph,
// and the default stability length for the scan decoder.
package seg_defs;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned STABLE_DEFAULT = 3;

  // Index n holds the active-low glyph for hex digit n (bit6=g .. bit0=a).
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph decoder: maps an active-low segment pattern to its hex
// nibble and flags legal hex glyphs and the blank glyph.
module seg_pattern_decode
  import seg_defs::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment scan bus.
// Optional saturating error counter output err_cnt enabled by SEG_ERR_CNT_EN.
module seg_scan_decoder
  import seg_defs::*;
#(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned STABLE = STABLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   digit_ok,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err,
  output logic              frame
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  logic [NDIG-1:0]   an_q, prev_an_q;
  logic [6:0]        seg_q, prev_seg_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   ok_q, ok_d;
  logic [NDIG-1:0]   seen_q, seen_d, seen_tmp;
  logic              upd_q, upd_d;
  logic [2:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              frame_q, frame_d;

  logic [3:0]        n_low;
  logic [2:0]        sel_idx;
  logic              valid, same, commit;
  logic [3:0]        nibble;
  logic              legal, blank;

  seg_pattern_decode u_dec (
    .seg    (seg_q),
    .nibble (nibble),
    .legal  (legal),
    .blank  (blank)
  );

  always_comb begin
    n_low   = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      n_low = n_low + {3'b000, ~an_q[i]};
      if (!an_q[i]) sel_idx = 3'(i);
    end
    valid = (n_low == 4'd1);
    same  = (an_q == prev_an_q) && (seg_q == prev_seg_q);

    if (!valid)
      cnt_d = '0;
    else if (same && (cnt_q != '0))
      cnt_d = (cnt_q == 4'(STABLE)) ? cnt_q : cnt_q + 4'd1;
    else
      cnt_d = 4'd1;

    // Commit only on the transition into STABLE so a held pair fires once.
    commit = valid && (cnt_d == 4'(STABLE)) && (cnt_q != 4'(STABLE));
  end

  always_comb begin
    value_d  = value_q;
    ok_d     = ok_q;
    seen_d   = seen_q;
    seen_tmp = seen_q | ~an_q;
    upd_d    = commit;
    idx_d    = commit ? sel_idx : '0;
    err_d    = commit && !legal && !blank;
    frame_d  = 1'b0;
    if (commit) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (!an_q[i]) begin
          ok_d[i] = legal;
          if (legal) value_d[4*i +: 4] = nibble;
        end
      end
      if (seen_tmp == '1) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_tmp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q       <= '0;
      seg_q      <= '0;
      prev_an_q  <= '0;
      prev_seg_q <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      ok_q       <= '0;
      seen_q     <= '0;
      upd_q      <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      an_q       <= an;
      seg_q      <= seg;
      prev_an_q  <= an_q;
      prev_seg_q <= seg_q;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      ok_q       <= ok_d;
      seen_q     <= seen_d;
      upd_q      <= upd_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
    end
  end

  assign value    = value_q;
  assign digit_ok = ok_q;
  assign upd      = upd_q;
  assign upd_idx  = idx_q;
  assign err      = err_q;
  assign frame    = frame_q;

`ifdef SEG_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= '0;
    else if (err_d && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
